// File: rtl/hash_arbiter_pkg.sv
// rtl/hash_arbiter_pkg.sv - shared state encoding and index-width helper for hash_arbiter
package HashArbPkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FEED = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

    function automatic int ArbIdx(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hash_arbiter_rr_pick.sv
// rtl/hash_arbiter_rr_pick.sv - grant selection: round-robin after i_ptr, or lowest index
// when HASH_ARB_FIXED_PRIO_EN is defined
module rr_pick
    import HashArbPkg::*;
#(
    parameter int NumReq = 2,
    localparam int IdxW = ArbIdx(NumReq)
) (
    input  logic [NumReq-1:0] i_req,
    input  logic [IdxW-1:0]   i_ptr,
    output logic [NumReq-1:0] o_grant,
    output logic [IdxW-1:0]   o_idx
);

`ifdef HASH_ARB_FIXED_PRIO_EN
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;

    // Walk downwards so the lowest requesting index is the last to overwrite.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (i_req[IdxW'(k)]) begin
                o_grant            = '0;
                o_grant[IdxW'(k)]  = 1'b1;
                o_idx              = IdxW'(k);
            end
        end
    end
`else
    // Offset 1 (the slot after the last grantee) must win, so walk offsets downwards.
    always_comb begin
        int j;
        j       = 0;
        o_grant = '0;
        o_idx   = '0;
        for (int k = NumReq; k >= 1; k--) begin
            j = (int'(i_ptr) + k) % NumReq;
            if (i_req[IdxW'(j)]) begin
                o_grant           = '0;
                o_grant[IdxW'(j)] = 1'b1;
                o_idx             = IdxW'(j);
            end
        end
    end
`endif

endmodule

// File: rtl/hash_arbiter.sv
// rtl/hash_arbiter.sv - shares one hash engine among NumReq requesters, one message per grant;
// HASH_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin
module hash_arbiter
    import HashArbPkg::*;
#(
    parameter int NumReq       = 2,
    parameter int IWidth       = 512,
    parameter int HashOutWidth = 512,
    parameter int BeatsPerHash = 2,
    localparam int IdxW = ArbIdx(NumReq)
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [NumReq-1:0]        ReqDataValid,
    output logic [NumReq-1:0]        ReqDataReady,
    input  logic [NumReq*IWidth-1:0] ReqData,
    output logic [NumReq-1:0]        ReqHashValid,
    input  logic [NumReq-1:0]        ReqHashReady,
    output logic [HashOutWidth-1:0]  ReqHash,
    output logic                     EngDataInValid,
    input  logic                     EngDataInReady,
    output logic [IWidth-1:0]        EngDataIn,
    input  logic                     EngHashOutValid,
    output logic                     EngHashOutReady,
    input  logic [HashOutWidth-1:0]  EngHashOut,
    output logic                     Busy,
    output logic [IdxW-1:0]          Owner
);

    localparam int CntW = $clog2(BeatsPerHash + 1);
    localparam logic [CntW-1:0] LastBeat = CntW'(BeatsPerHash - 1);
    localparam logic [IdxW-1:0] PtrInit  = IdxW'(NumReq - 1);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic [IdxW-1:0]   r_owner;
    logic [CntW-1:0]   r_beat_cnt;
    logic [IdxW-1:0]   w_ptr;
    logic [IdxW-1:0]   w_pick_idx;
    logic [NumReq-1:0] w_pick_grant;
    logic              w_data_hs;
    logic              w_hash_hs;
    logic [IWidth-1:0] w_req_data [NumReq];

    for (genvar g = 0; g < NumReq; g++) begin : g_unpack
        assign w_req_data[g] = ReqData[g*IWidth +: IWidth];
    end

`ifdef HASH_ARB_FIXED_PRIO_EN
    assign w_ptr = PtrInit;
`else
    logic [IdxW-1:0] r_ptr;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_ptr <= PtrInit;
        end else if (r_state == ST_WAIT && w_hash_hs) begin
            r_ptr <= r_owner;
        end
    end

    assign w_ptr = r_ptr;
`endif

    rr_pick #(.NumReq(NumReq)) u_pick (
        .i_req   (ReqDataValid),
        .i_ptr   (w_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx)
    );

    assign w_data_hs = EngDataInValid & EngDataInReady;
    assign w_hash_hs = EngHashOutValid & EngHashOutReady;
    assign Busy      = (r_state != ST_IDLE);
    assign Owner     = r_owner;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        ReqDataReady    = '0;
        ReqHashValid    = '0;
        ReqHash         = '0;
        EngDataInValid  = 1'b0;
        EngDataIn       = '0;
        EngHashOutReady = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_pick_grant) w_state_nxt = ST_FEED;
            end
            ST_FEED: begin
                EngDataIn             = w_req_data[r_owner];
                EngDataInValid        = ReqDataValid[r_owner];
                ReqDataReady[r_owner] = EngDataInReady;
                if (ReqDataValid[r_owner] && EngDataInReady && r_beat_cnt == LastBeat) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                ReqHashValid[r_owner] = EngHashOutValid;
                EngHashOutReady       = ReqHashReady[r_owner];
                ReqHash               = EngHashOut;
                if (EngHashOutValid && ReqHashReady[r_owner]) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_owner    <= '0;
            r_beat_cnt <= '0;
        end else begin
            if (r_state == ST_IDLE && |w_pick_grant) begin
                r_owner <= w_pick_idx;
            end
            if (r_state == ST_FEED && w_data_hs) begin
                r_beat_cnt <= (r_beat_cnt == LastBeat) ? '0 : r_beat_cnt + CntW'(1);
            end
        end
    end

endmodule

// File: tb/tb_hash_arbiter.sv
// tb/tb_hash_arbiter.sv - randomized and directed bench for hash_arbiter against a transaction-level model
module tb_hash_arbiter;

    localparam int NR  = 3;
    localparam int IW  = 16;
    localparam int HW  = 16;
    localparam int BPH = 2;
    localparam int OW  = HashArbPkg::ArbIdx(NR);

    logic           Clock = 1'b0;
    logic           Reset = 1'b1;
    logic [NR-1:0]  ReqDataValid = '0;
    logic [NR-1:0]  ReqDataReady;
    logic [NR*IW-1:0] ReqData = '0;
    logic [NR-1:0]  ReqHashValid;
    logic [NR-1:0]  ReqHashReady = '0;
    logic [HW-1:0]  ReqHash;
    logic           EngDataInValid;
    logic           EngDataInReady = 1'b0;
    logic [IW-1:0]  EngDataIn;
    logic           EngHashOutValid = 1'b0;
    logic           EngHashOutReady;
    logic [HW-1:0]  EngHashOut = '0;
    logic           Busy;
    logic [OW-1:0]  Owner;

    int total = 0;
    int bad   = 0;

    bit m_busy, m_wait;
    int m_owner, m_last, m_beats;
    int seq [NR];
    int eng_hs, wcnt, cyc, gapc;
    int engq [$];
    int deliv [$];
    int svc [$];

    hash_arbiter #(
        .NumReq(NR), .IWidth(IW), .HashOutWidth(HW), .BeatsPerHash(BPH)
    ) dut (
        .Clock(Clock), .Reset(Reset),
        .ReqDataValid(ReqDataValid), .ReqDataReady(ReqDataReady), .ReqData(ReqData),
        .ReqHashValid(ReqHashValid), .ReqHashReady(ReqHashReady), .ReqHash(ReqHash),
        .EngDataInValid(EngDataInValid), .EngDataInReady(EngDataInReady), .EngDataIn(EngDataIn),
        .EngHashOutValid(EngHashOutValid), .EngHashOutReady(EngHashOutReady), .EngHashOut(EngHashOut),
        .Busy(Busy), .Owner(Owner)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] v, input int last);
`ifdef HASH_ARB_FIXED_PRIO_EN
        for (int k = 0; k < NR; k++) if (v[k]) return k;
`else
        for (int k = 1; k <= NR; k++) if (v[(last + k) % NR]) return (last + k) % NR;
`endif
        return 0;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_wait = 0; m_owner = 0; m_last = NR - 1; m_beats = 0;
        wcnt = 0; gapc = 0;
        for (int i = 0; i < NR; i++) seq[i] = 0;
    endtask

    // One clock: compare at the falling edge, then advance the model past the rising edge.
    task automatic tick();
        logic [NR-1:0] exp_rdy, exp_hv, v;
        bit feed, waitp, data_hs, hash_hs;
        int pk;
        @(negedge Clock);
        feed = m_busy && !m_wait;
        waitp = m_busy && m_wait;
        exp_rdy = '0;
        exp_hv = '0;
        if (feed) exp_rdy[m_owner] = EngDataInReady;
        if (waitp) exp_hv[m_owner] = EngHashOutValid;
        v = ReqDataValid;
        check("busy", Busy, m_busy);
        check("owner", Owner, m_owner);
        check("data_ready", ReqDataReady, exp_rdy);
        check("eng_in_valid", EngDataInValid, feed && v[m_owner]);
        if (feed) check("eng_in_data", EngDataIn, ReqData[m_owner*IW +: IW]);
        check("hash_valid", ReqHashValid, exp_hv);
        check("eng_out_ready", EngHashOutReady, waitp && ReqHashReady[m_owner]);
        if (waitp) check("req_hash", ReqHash, EngHashOut);
        data_hs = feed && v[m_owner] && EngDataInReady;
        hash_hs = waitp && EngHashOutValid && ReqHashReady[m_owner];
        if (data_hs) begin
            engq.push_back(int'(EngDataIn));
            if (m_beats == 0) svc.push_back(int'(Owner));
        end
        if (hash_hs) deliv.push_back(int'(ReqHash));
        pk = pick(v, m_last);
        @(posedge Clock);
        #1;
        cyc++;
        if (!m_busy) begin
            if (|v) begin m_busy = 1; m_owner = pk; end
        end else if (data_hs) begin
            seq[m_owner]++;
            eng_hs++;
            m_beats++;
            if (m_beats == BPH) begin m_beats = 0; m_wait = 1; end
        end else if (hash_hs) begin
            m_last = m_owner; m_busy = 0; m_wait = 0;
        end
        wcnt = (m_busy && m_wait) ? wcnt + 1 : 0;
    endtask

    task automatic drive(input int mode);
        bit waitp;
        logic [NR-1:0] v;
        waitp = m_busy && m_wait;
        for (int i = 0; i < NR; i++) ReqData[i*IW +: IW] = IW'((i << 8) | (seq[i] & 255));
        case (mode)
            0: begin
                ReqDataValid    = NR'($urandom);
                EngDataInReady  = ($urandom_range(0, 9) < 7);
                EngHashOutValid = 1'($urandom_range(0, 1));
                EngHashOut      = HW'($urandom);
                ReqHashReady    = NR'($urandom);
            end
            1: begin
                ReqDataValid    = NR'(1);
                ReqData[0 +: IW] = (seq[0] % 2 == 0) ? IW'(16'h000A) : IW'(16'h000B);
                EngDataInReady  = 1'b1;
                EngHashOutValid = waitp;
                EngHashOut      = HW'(16'h0055);
                ReqHashReady    = '1;
            end
            2: begin
                ReqDataValid    = NR'(3);
                EngDataInReady  = 1'b1;
                EngHashOutValid = waitp;
                EngHashOut      = HW'($urandom);
                ReqHashReady    = '1;
            end
            3: begin
                ReqDataValid    = NR'(1);
                EngDataInReady  = (cyc % 2 == 0);
                EngHashOutValid = waitp;
                EngHashOut      = HW'(16'h1234);
                ReqHashReady    = (wcnt >= 4) ? '1 : '0;
            end
            4: begin
                v = NR'(2);
                v[0] = !(seq[0] % 2 == 1 && gapc < 4);
                gapc = (seq[0] % 2 == 1) ? gapc + 1 : 0;
                ReqDataValid    = v;
                EngDataInReady  = 1'b1;
                EngHashOutValid = waitp;
                EngHashOut      = HW'(16'h00C3);
                ReqHashReady    = '1;
            end
            default: begin
                ReqDataValid    = NR'(1);
                EngDataInReady  = 1'b1;
                EngHashOutValid = 1'b1;
                EngHashOut      = HW'(16'h0077);
                ReqHashReady    = '1;
            end
        endcase
    endtask

    task automatic run_deliv(input string tag, input int mode, input int n, input int limit);
        for (int k = 0; k < limit && deliv.size() < n; k++) begin
            drive(mode);
            tick();
        end
        check(tag, deliv.size() >= n, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && m_busy; k++) begin
            drive(0);
            ReqDataValid = '1; EngDataInReady = 1'b1; EngHashOutValid = 1'b1; ReqHashReady = '1;
            tick();
        end
        check("drain_timeout", m_busy, 0);
        ReqDataValid = '0; EngHashOutValid = 1'b0; EngDataInReady = 1'b0; ReqHashReady = '0;
        tick();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #2;
        check("rst_busy", Busy, 0);
        check("rst_owner", Owner, 0);
        check("rst_data_ready", ReqDataReady, 0);
        check("rst_eng_valid", EngDataInValid, 0);
        check("rst_hash_valid", ReqHashValid, 0);
        check("rst_eng_ready", EngHashOutReady, 0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        model_reset();
        engq.delete(); deliv.delete(); svc.delete();
        eng_hs = 0;
    endtask

    initial begin
        int exp_order [4];
`ifdef HASH_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        cyc = 0;
        model_reset();
        #1;
        do_reset();

        run_deliv("single_deliv", 1, 1, 30);
        check("single_beats", eng_hs, 2);
        check("single_beat0", engq[0], 'hA);
        check("single_beat1", engq[1], 'hB);
        check("single_digest", deliv[0], 'h55);
        drain();

        do_reset();
        for (int k = 0; k < 100 && svc.size() < 4; k++) begin
            drive(2);
            tick();
        end
        check("cont_count", svc.size() >= 4, 1);
        for (int i = 0; i < 4; i++) check($sformatf("cont_order%0d", i), svc[i], exp_order[i]);
        drain();

        do_reset();
        run_deliv("bp_deliv", 3, 1, 60);
        check("bp_beats", engq.size(), 2);
        check("bp_beat0", engq[0], 'h0000);
        check("bp_beat1", engq[1], 'h0001);
        check("bp_digest", deliv[0], 'h1234);
        drain();

        do_reset();
        run_deliv("gap_deliv", 4, 1, 60);
        check("gap_owner", svc[0], 0);
        check("gap_beats", engq.size() >= 2, 1);
        check("gap_beat1", engq[1], 'h0001);
        check("gap_digest", deliv[0], 'hC3);
        drain();

        do_reset();
        run_deliv("early_deliv", 5, 1, 30);
        check("early_digest", deliv[0], 'h77);
        drain();

        do_reset();
        for (int k = 0; k < 10 && m_beats != 1; k++) begin
            drive(1);
            tick();
        end
        check("mid_one_beat", m_beats, 1);
        do_reset();
        for (int k = 0; k < 10 && svc.size() < 1; k++) begin
            drive(2);
            ReqDataValid = NR'(3);
            tick();
        end
        check("mid_next_grant", svc.size() >= 1 ? svc[0] : -1, 0);
        drain();

        do_reset();
        repeat (3000) begin
            drive(0);
            tick();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
